extend_pipe: RTL and testbench

EXTEND_PIPE -- requirements
Module: extend_pipe

---
 rtl/extend_pipe.sv | 135 +++++++++++++
 tb/tb_extend_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/extend_pipe.sv
// -----------------------------------------------------------------------------
// extend_pipe
//   Immediate-extension stage with a 2-entry output FIFO. Each accepted
//   request decodes the immediate selected by immsrc from instr. The result
//   is computed at push time and queued in order. Requests with an illegal
//   format are queued with immext = 0 and out_err = 1, and they advance a
//   saturating error counter.
//
// Parameters
//   XLEN  : immediate output width (32 or 64)
//   CNTW  : width of the illegal-format counter
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset (has priority over push/pop)
//   in_valid   in   request present
//   in_ready   out  request can be accepted this cycle (registered occupancy)
//   instr      in   instruction word, bits [6:0] unused
//   immsrc     in   format select: I,S,B,J,U,shamt,CSR-uimm,illegal
//   out_valid  out  head entry valid
//   out_ready  in   consumer takes the head entry this cycle
//   immext     out  extended immediate of the head entry
//   out_err    out  head entry carried an illegal immsrc
//   err_cnt    out  saturating count of accepted illegal requests
// -----------------------------------------------------------------------------
module extend_pipe #(
  parameter int XLEN = 32,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immext,
  output logic            out_err,
  output logic [CNTW-1:0] err_cnt
);

  // FIFO storage and control
  logic [XLEN-1:0] r_imm [2];
  logic            r_err [2];
  logic            r_rd_ptr;
  logic            r_wr_ptr;
  logic [1:0]      r_count;
  logic [CNTW-1:0] r_err_cnt;

  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic            w_push;
  logic            w_pop;

  // The opcode field plays no part in immediate extraction.
  logic            w_unused_opcode;
  assign w_unused_opcode = ^instr[6:0];

  // Every format is first assembled as a 32-bit value whose bit 31 is the
  // required extension bit: instr[31] for the signed formats, 0 for the
  // zero-extended ones (shamt, CSR uimm) and for the illegal case. Widening
  // to XLEN is then a uniform replication of bit 31.
  always_comb begin
    w_imm32   = '0;
    w_illegal = 1'b0;
    case (immsrc)
      3'b000: w_imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b001: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: w_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
      3'b011: w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
      3'b100: w_imm32 = {instr[31:12], 12'b0};
      3'b101: begin
        // RV64 shift amounts are 6 bits wide, RV32 ones are 5 bits.
        if (XLEN == 64) w_imm32 = {26'b0, instr[25:20]};
        else            w_imm32 = {27'b0, instr[24:20]};
      end
      3'b110: w_imm32 = {27'b0, instr[19:15]};
      default: begin
        w_imm32   = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_imm[31:0] = w_imm32;

  genvar gi;
  generate
    for (gi = 32; gi < XLEN; gi++) begin : g_ext
      assign w_imm[gi] = w_imm32[31];
    end
  endgenerate

  // Handshakes; in_ready depends on registered occupancy only.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_imm[0]  <= '0;
      r_imm[1]  <= '0;
      r_err[0]  <= 1'b0;
      r_err[1]  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_err_cnt <= '0;
    end else begin
      if (w_push) begin
        r_imm[r_wr_ptr] <= w_imm;
        r_err[r_wr_ptr] <= w_illegal;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_push && w_illegal && (r_err_cnt != {CNTW{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign immext  = r_imm[r_rd_ptr];
  assign out_err = r_err[r_rd_ptr];
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_extend_pipe.sv
module tb_extend_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [2:0]  immsrc = 3'b0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] immext32;
  logic [7:0]  err_cnt32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] immext64;
  logic [7:0]  err_cnt64;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  extend_pipe #(.XLEN(32), .CNTW(8)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .out_valid(out_valid32),
    .out_ready(out_ready), .immext(immext32), .out_err(out_err32),
    .err_cnt(err_cnt32)
  );

  extend_pipe #(.XLEN(64), .CNTW(8)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .out_valid(out_valid64),
    .out_ready(out_ready), .immext(immext64), .out_err(out_err64),
    .err_cnt(err_cnt64)
  );

  // Hand-computed format table.
  localparam int NROW = 10;
  logic [31:0] t_instr [NROW] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000EE3,
                                  32'h00000463, 32'hFFDFF06F, 32'h123450B7,
                                  32'h800000B7, 32'h83F00093, 32'h800F8073,
                                  32'h7FF00093};
  logic [2:0]  t_src   [NROW] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4,
                                  3'd5, 3'd6, 3'd7};
  logic [31:0] t_exp32 [NROW] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC,
                                  32'h00000008, 32'hFFFFFFFC, 32'h12345000,
                                  32'h80000000, 32'h0000001F, 32'h0000001F,
                                  32'h00000000};
  logic [63:0] t_exp64 [NROW] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                  64'hFFFFFFFFFFFFFFFC, 64'h0000000000000008,
                                  64'hFFFFFFFFFFFFFFFC, 64'h0000000012345000,
                                  64'hFFFFFFFF80000000, 64'h000000000000003F,
                                  64'h000000000000001F, 64'h0000000000000000};
  logic        t_err   [NROW] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b1};

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    step();
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (out_valid32 !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid32);
    else pass_cnt++;
    total_cnt++;
    if (in_ready32 !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready32);
    else pass_cnt++;
    total_cnt++;
    if (immext32 !== 32'h0) $display("FAIL reset_immext got %h exp 00000000", immext32);
    else pass_cnt++;
    total_cnt++;
    if (out_err32 !== 1'b0) $display("FAIL reset_out_err got %b exp 0", out_err32);
    else pass_cnt++;
    total_cnt++;
    if (err_cnt32 !== 8'd0) $display("FAIL reset_err_cnt got %0d exp 0", err_cnt32);
    else pass_cnt++;
    $display("reset: out_valid=%b in_ready=%b err_cnt=%0d", out_valid32, in_ready32, err_cnt32);
  endtask

  task automatic test_i_s();
    do_reset();
    in_valid = 1'b1; instr = 32'hFFF00093; immsrc = 3'd0;
    step();
    $display("push I instr=%h", 32'hFFF00093);
    total_cnt++;
    if (out_valid32 !== 1'b1) $display("FAIL is_latency got out_valid=%b exp 1", out_valid32);
    else pass_cnt++;
    instr = 32'hFE20AE23; immsrc = 3'd1;
    step();
    $display("push S instr=%h", 32'hFE20AE23);
    in_valid = 1'b0;
    total_cnt++;
    if (immext32 !== 32'hFFFFFFFF || out_err32 !== 1'b0)
      $display("FAIL is_head_I got %h/%b exp ffffffff/0", immext32, out_err32);
    else pass_cnt++;
    total_cnt++;
    if (in_ready32 !== 1'b0) $display("FAIL is_full got in_ready=%b exp 0", in_ready32);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (immext32 !== 32'hFFFFFFFC || out_err32 !== 1'b0)
      $display("FAIL is_head_S got %h/%b exp fffffffc/0", immext32, out_err32);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid32 !== 1'b0) $display("FAIL is_drain got out_valid=%b exp 0", out_valid32);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  // Streams one request per cycle with out_ready held high; each row must
  // appear at the head right after its push edge.
  task automatic test_formats();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < NROW; i++) begin
      in_valid = 1'b1; instr = t_instr[i]; immsrc = t_src[i];
      step();
      $display("row %0d instr=%h src=%0d imm32=%h imm64=%h err=%b",
               i, t_instr[i], t_src[i], immext32, immext64, out_err32);
      total_cnt++;
      if (immext32 !== t_exp32[i] || out_err32 !== t_err[i] || out_valid32 !== 1'b1)
        $display("FAIL fmt32_row%0d got %h/%b/%b exp %h/%b/1", i, immext32, out_err32,
                 out_valid32, t_exp32[i], t_err[i]);
      else pass_cnt++;
      total_cnt++;
      if (immext64 !== t_exp64[i] || out_err64 !== t_err[i])
        $display("FAIL fmt64_row%0d got %h/%b exp %h/%b", i, immext64, out_err64,
                 t_exp64[i], t_err[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    total_cnt++;
    if (out_valid32 !== 1'b0 || err_cnt32 !== 8'd1 || err_cnt64 !== 8'd1)
      $display("FAIL fmt_end got valid=%b cnt32=%0d cnt64=%0d exp 0/1/1",
               out_valid32, err_cnt32, err_cnt64);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; instr = 32'h00100093; immsrc = 3'd0;
    step();
    total_cnt++;
    if (in_ready32 !== 1'b1) $display("FAIL bp_one got in_ready=%b exp 1", in_ready32);
    else pass_cnt++;
    instr = 32'h00200093;
    step();
    total_cnt++;
    if (in_ready32 !== 1'b0) $display("FAIL bp_two got in_ready=%b exp 0", in_ready32);
    else pass_cnt++;
    instr = 32'h00300093;
    step();
    step();
    total_cnt++;
    if (in_ready32 !== 1'b0 || immext32 !== 32'd1)
      $display("FAIL bp_hold got in_ready=%b head=%h exp 0/00000001", in_ready32, immext32);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    $display("bp pop head=%h", immext32);
    total_cnt++;
    if (immext32 !== 32'd2 || in_ready32 !== 1'b1)
      $display("FAIL bp_rel1 got head=%h in_ready=%b exp 00000002/1", immext32, in_ready32);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    $display("bp pop head=%h", immext32);
    total_cnt++;
    if (immext32 !== 32'd3 || out_valid32 !== 1'b1)
      $display("FAIL bp_rel2 got head=%h valid=%b exp 00000003/1", immext32, out_valid32);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid32 !== 1'b0) $display("FAIL bp_nodup got out_valid=%b exp 0", out_valid32);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 32'hFFFFFFFF; immsrc = 3'd7;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 0) begin
        total_cnt++;
        if (out_err32 !== 1'b1 || immext32 !== 32'h0 || err_cnt32 !== 8'd1)
          $display("FAIL ill_first got err=%b imm=%h cnt=%0d exp 1/00000000/1",
                   out_err32, immext32, err_cnt32);
        else pass_cnt++;
      end
      if (i == 253) begin
        total_cnt++;
        if (err_cnt32 !== 8'd254) $display("FAIL ill_254 got %0d exp 254", err_cnt32);
        else pass_cnt++;
      end
      if (i == 254) begin
        total_cnt++;
        if (err_cnt32 !== 8'd255) $display("FAIL ill_255 got %0d exp 255", err_cnt32);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    $display("illegal x300: err_cnt=%0d out_err=%b", err_cnt32, out_err32);
    total_cnt++;
    if (err_cnt32 !== 8'd255 || out_err32 !== 1'b1 || immext32 !== 32'h0)
      $display("FAIL ill_sat got cnt=%0d err=%b imm=%h exp 255/1/00000000",
               err_cnt32, out_err32, immext32);
    else pass_cnt++;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 32'h0; immsrc = 3'd7;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b0;
    instr = 32'h00700093; immsrc = 3'd0;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (err_cnt32 !== 8'd5 || in_ready32 !== 1'b0)
      $display("FAIL mid_pre got cnt=%0d in_ready=%b exp 5/0", err_cnt32, in_ready32);
    else pass_cnt++;
    // Reset coinciding with a push and a pop: reset wins.
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; immsrc = 3'd7;
    step();
    reset = 1'b0; in_valid = 1'b0;
    $display("reset mid: out_valid=%b in_ready=%b err_cnt=%0d", out_valid32, in_ready32, err_cnt32);
    total_cnt++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || err_cnt32 !== 8'd0 || immext32 !== 32'h0)
      $display("FAIL mid_post got valid=%b ready=%b cnt=%0d imm=%h exp 0/1/0/00000000",
               out_valid32, in_ready32, err_cnt32, immext32);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (out_valid32 !== 1'b0) $display("FAIL mid_stale%0d got out_valid=%b exp 0", i, out_valid32);
      else pass_cnt++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i_s();
    test_formats();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
